// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and the round-robin winner function for the UART transmit arbiter.
// Imported by rr_pick and uart_tx_arbiter.
package uart_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int ID_MAX_W = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      WAIT    = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } arb_state_t;

   // Searches upward from last+1, wrapping at num_req, and returns the first valid index.
   function automatic logic [ID_MAX_W-1:0] rr_winner(input logic [MAX_REQ-1:0]  valid,
                                                      input logic [ID_MAX_W-1:0] last,
                                                      input int                  num_req);
      logic [ID_MAX_W-1:0] win;
      logic                found;
      int                  idx;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         idx = (int'(last) + i) % num_req;
         if (i <= num_req && !found && valid[ID_MAX_W'(idx)]) begin
            win   = ID_MAX_W'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tx_start;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_busy;
   logic                          tx_done;
   logic                          grant_valid;
   logic [IDW-1:0]                grant_id;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy, tx_done,
      output req_ready, tx_start, tx_data, grant_valid, grant_id
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy, tx_done,
      input  req_ready, tx_start, tx_data, grant_valid, grant_id
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner selection for the arbiter: round-robin from last_grant+1,
// or lowest-index-first when ARB_FIXED_PRIORITY_EN is defined.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDW-1:0]     last_grant,
   output logic [IDW-1:0]     winner,
   output logic               any_valid
);

   assign any_valid = |req_valid;

`ifdef ARB_FIXED_PRIORITY_EN
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   always_comb begin
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            winner = IDW'(i);
         end
      end
   end
`else
   assign winner = IDW'(rr_winner(MAX_REQ'(req_valid), ID_MAX_W'(last_grant), NUM_REQ));
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters, holding a grant
// for a packet up to MAX_BURST bytes. ARB_FIXED_PRIORITY_EN selects fixed priority.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_BURST    = 4,
   parameter int HOLD_TIMEOUT = 16
) (
   input logic               clk,
   input logic               rstn,
   uart_tx_arbiter_if.slave  bus
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int BW  = $clog2(MAX_BURST + 1);
   localparam int HW  = $clog2(HOLD_TIMEOUT + 1);

   arb_state_t            state, next_state;
   logic [IDW-1:0]        grant_id, last_grant, winner;
   logic                  grant_valid, any_valid;
   logic [BW-1:0]         burst_cnt;
   logic [HW-1:0]         hold_cnt;
   logic                  tx_start, last_q;
   logic [DATA_WIDTH-1:0] tx_data, sel_data;
   logic                  sel_valid, sel_last;
   logic                  transfer, done_ok, burst_end, hold_end;
   logic [NUM_REQ-1:0]    req_ready;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_valid = bus.req_valid[i];
            sel_last  = bus.req_last[i];
            sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A done pulse coinciding with our own start pulse belongs to an older frame.
   assign transfer  = (state == LOAD) && !bus.tx_busy && sel_valid;
   assign done_ok   = (state == WAIT) && bus.tx_done && !tx_start;
   assign burst_end = (burst_cnt == BW'(MAX_BURST - 1));
   assign hold_end  = (hold_cnt == HW'(HOLD_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_valid) next_state = LOAD;
         LOAD:    if (!bus.tx_busy) next_state = sel_valid ? WAIT : RELEASE;
         WAIT:    if (done_ok) next_state = (last_q || burst_end) ? RELEASE : HOLD;
         HOLD: begin
            if (sel_valid) begin
               next_state = LOAD;
            end else if (hold_end) begin
               next_state = RELEASE;
            end
         end
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant_id    <= '0;
         grant_valid <= 1'b0;
         last_grant  <= IDW'(NUM_REQ - 1);
         burst_cnt   <= '0;
         hold_cnt    <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         last_q      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id    <= winner;
                  grant_valid <= 1'b1;
                  burst_cnt   <= '0;
               end
            end
            LOAD: begin
               if (transfer) begin
                  tx_data  <= sel_data;
                  last_q   <= sel_last;
                  tx_start <= 1'b1;
               end
            end
            WAIT: begin
               if (done_ok && !(last_q || burst_end)) begin
                  burst_cnt <= burst_cnt + 1'b1;
                  hold_cnt  <= '0;
               end
            end
            HOLD: begin
               if (!sel_valid && !hold_end) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               last_grant  <= grant_id;
               grant_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = '0;
      if (transfer) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.tx_start    = tx_start;
   assign bus.tx_data     = tx_data;
   assign bus.grant_valid = grant_valid;
   assign bus.grant_id    = grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requesters, a simple transmitter
// model and a scoreboard of expected (owner, byte) pairs per tx_start.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int DATA_WIDTH   = 8;
   localparam int MAX_BURST    = 4;
   localparam int HOLD_TIMEOUT = 16;
   localparam int FRAME_LEN    = 4;
   localparam int IDW          = 2;
   localparam int LIMIT        = 600;

   typedef struct packed {
      logic [IDW-1:0]        id;
      logic [DATA_WIDTH-1:0] data;
   } sb_entry_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
      .MAX_BURST(MAX_BURST), .HOLD_TIMEOUT(HOLD_TIMEOUT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   logic [NUM_REQ-1:0]            req_valid, req_last, accepted;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          model_busy, force_busy, tx_done, start_now, outstanding;
   logic [8:0]                    drv_head;
   int                            frame_cnt;

   assign bus.req_valid = req_valid;
   assign bus.req_data  = req_data;
   assign bus.req_last  = req_last;
   assign bus.tx_busy   = model_busy | force_busy;
   assign bus.tx_done   = tx_done;

   logic [8:0] src_q [NUM_REQ][$];
   sb_entry_t  exp_q[$];
   sb_entry_t  obs_q[$];
   int checks = 0, errors = 0, overlap_viol = 0, ready_viol = 0;

   // Monitor: records each start and flags starts that overlap an unfinished frame.
   initial begin
      accepted    = '0;
      outstanding = 1'b0;
      forever begin
         @(negedge clk);
         accepted = bus.req_valid & bus.req_ready;
         if (bus.req_ready != '0 &&
             (!bus.grant_valid || bus.req_ready != (NUM_REQ'(1) << bus.grant_id)))
            ready_viol++;
         if (bus.tx_start) begin
            if (outstanding) overlap_viol++;
            outstanding = 1'b1;
            obs_q.push_back({bus.grant_id, bus.tx_data});
         end else if (bus.tx_done) begin
            outstanding = 1'b0;
         end
      end
   end

   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               drv_head = src_q[i][0];
               req_valid[i] = 1'b1;
               req_last[i]  = drv_head[8];
               req_data[i*DATA_WIDTH +: DATA_WIDTH] = drv_head[7:0];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Transmitter model: busy for FRAME_LEN cycles after each start, then a done pulse.
   initial begin
      model_busy = 1'b0;
      tx_done    = 1'b0;
      frame_cnt  = 0;
      forever begin
         @(negedge clk);
         start_now = bus.tx_start;
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) begin
               model_busy = 1'b0;
               tx_done    = 1'b1;
            end
         end
         if (start_now) begin
            model_busy = 1'b1;
            frame_cnt  = FRAME_LEN;
         end
      end
   end

   task automatic push_byte(input int r, input logic [7:0] d, input logic last);
      src_q[r].push_back({last, d});
   endtask

   task automatic expect_byte(input int r, input logic [7:0] d);
      exp_q.push_back({IDW'(r), d});
   endtask

   task automatic apply_reset();
      rstn       = 1'b0;
      force_busy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_obs(input int n);
      int k = 0;
      while (obs_q.size() < n && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (obs_q.size() < n) begin
         errors++;
         $display("[TB] FAIL start_timeout: got %0d starts, required %0d", obs_q.size(), n);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(bus.grant_valid == 1'b0 && !model_busy && req_valid == '0) && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= LIMIT) begin
         errors++;
         $display("[TB] FAIL idle_timeout: grant_valid %b busy %b req_valid %b, required idle",
                  bus.grant_valid, model_busy, req_valid);
      end
      @(negedge clk);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!bus.tx_done && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (!bus.tx_done) begin
         errors++;
         $display("[TB] FAIL done_timeout: tx_done %b, required 1", bus.tx_done);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      force_busy = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.req_ready} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_values: start %b data %h gv %b id %0d ready %b, required all 0",
                  bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.req_ready);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_packet();
      sb_entry_t e, g;
      apply_reset();
      push_byte(2, 8'hA5, 1'b0);  expect_byte(2, 8'hA5);
      push_byte(2, 8'h5A, 1'b1);  expect_byte(2, 8'h5A);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL t1_grant_latency: gv %b id %0d ready %b, required 1 2 0100",
                  bus.grant_valid, bus.grant_id, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL t1_start_latency: start %b data %h, required 1 a5",
                  bus.tx_start, bus.tx_data);
      end
      wait_obs(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (g !== e) begin
            errors++;
            $display("[TB] FAIL t1_byte: got id %0d data %h, required id %0d data %h",
                     g.id, g.data, e.id, e.data);
         end
      end
      wait_done();
      @(negedge clk);
      checks++;
      if (bus.grant_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t1_release_cycle: gv %b, required 1", bus.grant_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd2) begin
         errors++;
         $display("[TB] FAIL t1_released: gv %b id %0d, required 0 2",
                  bus.grant_valid, bus.grant_id);
      end
      wait_idle();
   endtask

   task automatic test_round_robin();
      sb_entry_t e, g;
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         push_byte(i, 8'(8'h10 + i), 1'b1);
         expect_byte(i, 8'(8'h10 + i));
      end
      wait_obs(NUM_REQ);
      wait_idle();
      push_byte(0, 8'h99, 1'b1);
      expect_byte(0, 8'h99);
      wait_obs(NUM_REQ + 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (g !== e) begin
            errors++;
            $display("[TB] FAIL t2_order: got id %0d data %h, required id %0d data %h",
                     g.id, g.data, e.id, e.data);
         end
      end
      wait_idle();
   endtask

   task automatic test_burst_cap();
      sb_entry_t e, g;
      apply_reset();
      for (int i = 0; i < 6; i++) push_byte(1, 8'(8'h40 + i), 1'b0);
      push_byte(3, 8'hC3, 1'b1);
      for (int i = 0; i < MAX_BURST; i++) expect_byte(1, 8'(8'h40 + i));
      expect_byte(3, 8'hC3);
      for (int i = MAX_BURST; i < 6; i++) expect_byte(1, 8'(8'h40 + i));
      wait_obs(7);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (g !== e) begin
            errors++;
            $display("[TB] FAIL t3_burst: got id %0d data %h, required id %0d data %h",
                     g.id, g.data, e.id, e.data);
         end
      end
      wait_idle();
   endtask

   task automatic test_hold_timeout();
      sb_entry_t e, g;
      int held;
      apply_reset();
      push_byte(0, 8'h3C, 1'b0);
      expect_byte(0, 8'h3C);
      wait_obs(1);
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (g !== e) begin
         errors++;
         $display("[TB] FAIL t4_byte: got id %0d data %h, required id %0d data %h",
                  g.id, g.data, e.id, e.data);
      end
      wait_done();
      held = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.grant_valid !== 1'b1) break;
         held++;
      end
      checks++;
      if (held != HOLD_TIMEOUT + 1) begin
         errors++;
         $display("[TB] FAIL t4_hold_cycles: got %0d, required %0d", held, HOLD_TIMEOUT + 1);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || bus.grant_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL t4_no_restart: extra starts %0d gv %b, required 0 0",
                  obs_q.size(), bus.grant_valid);
      end
      wait_idle();
   endtask

   task automatic test_busy_stall();
      sb_entry_t e, g;
      apply_reset();
      force_busy = 1'b1;
      push_byte(2, 8'hB7, 1'b1);
      expect_byte(2, 8'hB7);
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t5_stall_%0d: ready %b start %b gv %b, required 0000 0 1",
                     k, bus.req_ready, bus.tx_start, bus.grant_valid);
         end
      end
      @(posedge clk);
      #1;
      force_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL t5_ready: got %b, required 0100", bus.req_ready);
      end
      wait_obs(1);
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (g !== e) begin
         errors++;
         $display("[TB] FAIL t5_byte: got id %0d data %h, required id %0d data %h",
                  g.id, g.data, e.id, e.data);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_wait();
      sb_entry_t e, g;
      int k;
      apply_reset();
      push_byte(3, 8'h77, 1'b1);
      expect_byte(3, 8'h77);
      wait_obs(1);
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.req_ready} !== '0) begin
         errors++;
         $display("[TB] FAIL t6_async_reset: start %b data %h gv %b id %0d ready %b, required all 0",
                  bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.req_ready);
      end
      push_byte(2, 8'h22, 1'b1);
      push_byte(1, 8'h11, 1'b1);
      expect_byte(1, 8'h11);
      expect_byte(2, 8'h22);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      k = 0;
      while (bus.grant_valid !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin
         errors++;
         $display("[TB] FAIL t6_first_grant: gv %b id %0d, required 1 1",
                  bus.grant_valid, bus.grant_id);
      end
      wait_obs(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         checks++;
         if (g !== e) begin
            errors++;
            $display("[TB] FAIL t6_byte: got id %0d data %h, required id %0d data %h",
                     g.id, g.data, e.id, e.data);
         end
      end
      wait_idle();
   endtask

   initial begin
      rstn       = 1'b0;
      force_busy = 1'b0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_burst_cap();
      test_hold_timeout();
      test_busy_stall();
      test_reset_mid_wait();
      checks++;
      if (overlap_viol != 0 || ready_viol != 0) begin
         errors++;
         $display("[TB] FAIL protocol: overlapping starts %0d bad ready %0d, required 0 0",
                  overlap_viol, ready_viol);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (start/busy/done handshake) among NUM_REQ byte-stream requesters on the system bus side. Grants round-robin, then holds the grant for a multi-byte packet until the requester's last flag, the burst cap or the hold timeout. It feeds bytes to the transmitter one at a time and waits for each frame to complete. It sits between the bus-side requesters and the single uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; matches the transmitter
MAX_BURST, 4, maximum bytes per grant before forced rotation (>=1)
HOLD_TIMEOUT, 16, cycles to wait in HOLD for the next byte before release (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  byte is the last of its packet
req_ready  out  NUM_REQ  one-hot accept pulse
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  DATA_WIDTH  byte to the transmitter, held until the next load
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle frame-complete pulse
grant_valid  out  1  a requester currently owns the transmitter
grant_id  out  $clog2(NUM_REQ)  current or last owner

Behaviour:
- Reset (clk, rstn: asynchronous, active-low) values:
  - tx_start=0, tx_data=0, grant_valid=0, grant_id=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - burst_cnt=0, hold_cnt=0, state=IDLE.
- req_ready is combinational: req_ready[grant_id] = (state==LOAD && !tx_busy && req_valid[grant_id]); all other bits 0. A transfer is valid&&ready.
- Requesters hold req_valid/req_data/req_last stable until ready.
- States:
  - IDLE: if any req_valid, winner = first valid index searching from last_grant+1 modulo NUM_REQ. Register grant_id=winner, grant_valid=1, burst_cnt=0; go to LOAD. Otherwise stay.
  - LOAD: if tx_busy=1, stay (no ready, no start). If tx_busy=0 and req_valid[grant_id]=1, the transfer happens. Register tx_data=req_data byte, last_q=req_last bit, and tx_start=1 for the next cycle only; go to WAIT. If tx_busy=0 and req_valid[grant_id]=0, go to RELEASE.
  - WAIT: on tx_done, go to RELEASE if last_q=1 or burst_cnt==MAX_BURST-1. Otherwise burst_cnt++, hold_cnt=0, go to HOLD. A tx_done in the same cycle as the tx_start pulse is ignored; only a tx_done after the start counts.
  - HOLD: if req_valid[grant_id], go to LOAD. Otherwise hold_cnt++; when hold_cnt reaches HOLD_TIMEOUT-1, go to RELEASE.
  - RELEASE (one cycle): last_grant=grant_id, grant_valid=0, go to IDLE. grant_id keeps its value.
- Latency: req_valid rising in IDLE at cycle 0 gives grant at cycle 1, req_ready at cycle 1 (if not busy) and tx_start at cycle 2.
- Only one byte is outstanding at a time. A new tx_start never occurs before tx_done of the previous byte.
- Multiple requesters valid at once: exactly one is granted. Other requesters see req_ready=0 until their turn.
- Reset mid-operation returns to IDLE with the reset values. A partially sent byte is the transmitter's concern; the arbiter does not re-send it.
- Counter widths: burst_cnt is $clog2(MAX_BURST+1) bits; hold_cnt is $clog2(HOLD_TIMEOUT+1) bits; neither wraps.

Optional Feature:
Macro ARB_FIXED_PRIORITY_EN.
- Defined: IDLE picks the lowest-index valid requester. last_grant is unused for selection. MAX_BURST and HOLD_TIMEOUT behave unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package uart_arb_pkg: state encoding localparams (IDLE, LOAD, WAIT, HOLD, RELEASE) and a function computing the round-robin winner index from the valid vector and the pointer.
- One sub-module, rr_pick: combinational winner and any-valid from (req_valid, last_grant). Its fixed-priority variant is selected by the macro.

Test Plan:
1. Requester 2 sends 0xA5 (last=0) then 0x5A (last=1), others idle -> grant_id=2 throughout; two tx_start pulses with tx_data 0xA5, then 0x5A each after tx_done; grant_valid drops after the second tx_done.
2. All 4 valid, one byte each with last=1, after reset -> grant order 0,1,2,3; reasserting requester 0 afterwards grants 0 again.
3. Requester 1 streams 6 bytes with last=0, requester 3 valid, MAX_BURST=4 -> 4 bytes from requester 1, then grant_id=3, then requester 1 resumes.
4. Requester 0 sends 1 byte with last=0 then idles, HOLD_TIMEOUT=16 -> release 16 cycles after entering HOLD; no further tx_start.
5. tx_busy held high for 5 cycles while in LOAD -> req_ready=0 and tx_start=0 for those cycles; transfer on the first cycle tx_busy=0.
6. rstn pulsed low during WAIT -> all outputs return to reset values immediately; next arbitration grants the lowest valid index.
